branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Parametrised successor to the combinational branch decoder.
- Owns the architectural PC register and the NVZ flag register.
- Evaluates the 8 branch conditions against the registered flags and computes PC-relative or register targets.
- Sequences a fixed-length pipeline flush after each taken branch, and holds a sticky halt state. Sits between fetch and decode in the WISC CPU.

Parameters:
- PC_W, 16, PC and target width.
- OFF_W, 9, signed branch offset width, in instruction words.
- FLUSH_CYC, 2, cycles flush is held after a taken branch. Legal range 1..7.
- RESET_PC, 16'h0000, PC value on reset.

Ports:
- clk, input, 1, clock. All state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- stall, input, 1, freezes PC, FSM and flush counter.
- valid_br, input, 1, a branch instruction is present in decode this cycle.
- br_reg, input, 1, 1 = register-target form (BR); 0 = PC-relative form (B).
- cond, input, 3, condition code.
- offset, input, OFF_W, signed word offset.
- br_addr, input, PC_W, register target for the BR form.
- flags_in, input, 3, new flag values, bit order {N,V,Z}.
- flag_we, input, 3, per-bit write enables for flags_in.
- halt, input, 1, HLT instruction in decode.
- pc_out, output, PC_W, registered PC.
- pc_plus2, output, PC_W, pc_out+2, combinational.
- flush, output, 1, squash younger instructions.
- taken, output, 1, registered one-cycle pulse after each redirect.
- halted, output, 1, high in the HALT state.
- taken_cnt, output, 16, saturating count of taken branches.

Behaviour:
- Reset (async, rst_n=0):
  - pc_out=RESET_PC; flags=3'b000; state=RUN.
  - flush=0, taken=0, halted=0, taken_cnt=0, flush counter=0.
- Flags:
  - Each flag bit i loads flags_in[i] when flag_we[i]=1, regardless of stall or state.
  - Condition evaluation uses the registered flags only. A write in the same cycle is not bypassed; it is visible from the next cycle.
- Conditions (Z, N, V = registered flags):
  - 000: Z=0.
  - 001: Z=1.
  - 010: Z=0 and N=0.
  - 011: N=1.
  - 100: Z=1 or (Z=0 and N=0).
  - 101: N=1 or Z=1.
  - 110: V=1.
  - 111: always.
- Target arithmetic, modulo 2^PC_W:
  - B form: pc_plus2 + (sign_extend(offset) << 1).
  - BR form: br_addr. Condition still applies.
- FSM states: RUN, FLUSH, HALT.
  - RUN, stall=1: hold everything.
  - RUN, halt=1: enter HALT; pc holds. Halt has priority over a simultaneous branch, which is dropped (no flush, no count).
  - RUN, valid_br=1 and condition true: pc<=target; enter FLUSH with counter=FLUSH_CYC; taken pulses next cycle; taken_cnt increments unless already 16'hFFFF.
  - RUN, otherwise: pc<=pc_plus2.
  - FLUSH: flush=1 while in this state. pc<=pc_plus2 each unstalled cycle. Counter decrements each unstalled cycle; return to RUN when it reaches 0. valid_br and halt are ignored (squashed).
  - HALT: pc frozen, halted=1. Leave only via reset.
- Stall in FLUSH: counter and pc hold; flush stays 1.
- Reset asserted mid-FLUSH: immediate return to reset values.
- PC wrap: 16'hFFFE+2 = 16'h0000. Target wrap is ignored (no trap).

Test Plan:
- Reset then 3 unstalled cycles, no branches -> pc_out 0000, 0002, 0004, 0006; flush=0; taken_cnt=0.
- Flags Z=1 written at cycle t, valid_br cond=001 offset=9'h004 at t (pc=0010) -> not taken, pc=0012. The same branch at t+1 (pc=0012) -> pc=001C, taken pulse, flush high for exactly 2 cycles.
- pc=0020, cond=111, offset=9'h1FE (-2) -> pc=001E. BR form with br_addr=ABCD and cond=110, V=1 -> pc=ABCD.
- Taken branch followed by stall for 3 cycles during FLUSH -> flush stays high for 2 unstalled cycles + 3 stalled cycles; pc frozen while stalled.
- halt and a taken valid_br in the same cycle -> HALT, pc frozen, halted=1, taken_cnt unchanged. rst_n pulse -> pc=0000, RUN.
- Preload 65535 taken branches, then one more -> taken_cnt stays FFFF. pc=FFFE unstalled -> 0000.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Branch/PC unit for the WISC pipeline: owns the architectural PC and the
// {N,V,Z} flag register, resolves branches at decode, and sequences the
// post-branch flush and the sticky halt state.
module branch_pc_unit #(
  parameter int              PC_W      = 16,
  parameter int              OFF_W     = 9,
  parameter int              FLUSH_CYC = 2,
  parameter logic [PC_W-1:0] RESET_PC  = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             valid_br,
  input  logic             br_reg,
  input  logic [2:0]       cond,
  input  logic [OFF_W-1:0] offset,
  input  logic [PC_W-1:0]  br_addr,
  input  logic [2:0]       flags_in,
  input  logic [2:0]       flag_we,
  input  logic             halt,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  pc_plus2,
  output logic             flush,
  output logic             taken,
  output logic             halted,
  output logic [15:0]      taken_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [2:0]      r_flags;     // {N,V,Z}
  logic [2:0]      r_cnt;
  logic            r_flush;
  logic            r_taken;
  logic            r_halted;
  logic [15:0]     r_taken_cnt;

  logic            w_n;
  logic            w_v;
  logic            w_z;
  logic            w_cond_true;
  logic [PC_W-1:0] w_pc_plus2;
  logic [PC_W-1:0] w_off_sext;
  logic [PC_W-1:0] w_b_target;
  logic [PC_W-1:0] w_target;

  assign w_n = r_flags[2];
  assign w_v = r_flags[1];
  assign w_z = r_flags[0];

  // Each flag bit has its own write enable and ignores stall/state; the
  // new value is only seen by condition evaluation from the next cycle.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_flag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_flags[gi] <= 1'b0;
        else if (flag_we[gi])
          r_flags[gi] <= flags_in[gi];
      end
    end
  endgenerate

  // Branch condition decode against the registered flags.
  always_comb begin
    w_cond_true = 1'b0;
    case (cond)
      3'b000: w_cond_true = ~w_z;
      3'b001: w_cond_true = w_z;
      3'b010: w_cond_true = ~w_z & ~w_n;
      3'b011: w_cond_true = w_n;
      3'b100: w_cond_true = w_z | (~w_z & ~w_n);
      3'b101: w_cond_true = w_n | w_z;
      3'b110: w_cond_true = w_v;
      3'b111: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Offset is in instruction words, so it is doubled before the add;
  // all arithmetic wraps modulo 2^PC_W.
  assign w_pc_plus2 = r_pc + PC_W'(2);
  assign w_off_sext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign w_b_target = w_pc_plus2 + {w_off_sext[PC_W-2:0], 1'b0};
  assign w_target   = br_reg ? br_addr : w_b_target;

  // Control FSM: PC update, flush countdown, halt, taken pulse and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_cnt       <= 3'd0;
      r_flush     <= 1'b0;
      r_taken     <= 1'b0;
      r_halted    <= 1'b0;
      r_taken_cnt <= 16'd0;
    end else begin
      r_taken <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (!stall) begin
            if (halt) begin
              // Halt wins over a simultaneous branch; the branch is dropped.
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else if (valid_br && w_cond_true) begin
              r_pc    <= w_target;
              r_state <= ST_FLUSH;
              r_cnt   <= FLUSH_INIT;
              r_flush <= 1'b1;
              r_taken <= 1'b1;
              if (r_taken_cnt != 16'hFFFF)
                r_taken_cnt <= r_taken_cnt + 16'd1;
            end else begin
              r_pc <= w_pc_plus2;
            end
          end
        end
        ST_FLUSH: begin
          // Younger branch/halt in decode are squashed here.
          if (!stall) begin
            r_pc  <= w_pc_plus2;
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
              r_state <= ST_RUN;
              r_flush <= 1'b0;
            end
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state  <= ST_RUN;
          r_flush  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out    = r_pc;
  assign pc_plus2  = w_pc_plus2;
  assign flush     = r_flush;
  assign taken     = r_taken;
  assign halted    = r_halted;
  assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with hand-computed expected values.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        valid_br;
  logic        br_reg;
  logic [2:0]  cond;
  logic [8:0]  offset;
  logic [15:0] br_addr;
  logic [2:0]  flags_in;
  logic [2:0]  flag_we;
  logic        halt;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        flush;
  logic        taken;
  logic        halted;
  logic [15:0] taken_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  branch_pc_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .valid_br  (valid_br),
    .br_reg    (br_reg),
    .cond      (cond),
    .offset    (offset),
    .br_addr   (br_addr),
    .flags_in  (flags_in),
    .flag_we   (flag_we),
    .halt      (halt),
    .pc_out    (pc_out),
    .pc_plus2  (pc_plus2),
    .flush     (flush),
    .taken     (taken),
    .halted    (halted),
    .taken_cnt (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [15:0] exp_pc, input logic exp_flush);
    check({tag, " pc"}, {16'd0, pc_out}, {16'd0, exp_pc});
    check({tag, " flush"}, {31'd0, flush}, {31'd0, exp_flush});
    $display("step %-14s pc=%h flush=%b taken=%b halted=%b cnt=%h",
             tag, pc_out, flush, taken, halted, taken_cnt);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; valid_br = 1'b0; br_reg = 1'b0;
    cond = 3'd0; offset = 9'd0; br_addr = 16'd0; flags_in = 3'd0;
    flag_we = 3'd0; halt = 1'b0;

    // Reset state
    repeat (2) step();
    chk_pc("reset", 16'h0000, 1'b0);
    check("reset taken", {31'd0, taken}, 32'd0);
    check("reset halted", {31'd0, halted}, 32'd0);
    check("reset cnt", {16'd0, taken_cnt}, 32'd0);
    rst_n = 1'b1;
    check("pc_plus2", {16'd0, pc_plus2}, 32'h0002);

    // Sequential fetch
    step(); chk_pc("seq1", 16'h0002, 1'b0);
    step(); chk_pc("seq2", 16'h0004, 1'b0);
    step(); chk_pc("seq3", 16'h0006, 1'b0);
    check("seq cnt", {16'd0, taken_cnt}, 32'd0);
    repeat (5) step();
    chk_pc("seq8", 16'h0010, 1'b0);

    // Z written in the same cycle is not bypassed
    flags_in = 3'b001; flag_we = 3'b001;
    valid_br = 1'b1; cond = 3'b001; offset = 9'h004;
    step(); chk_pc("beq_nobypass", 16'h0012, 1'b0);
    check("nobypass taken", {31'd0, taken}, 32'd0);
    flag_we = 3'b000;
    step(); chk_pc("beq_taken", 16'h001C, 1'b1);
    check("beq taken pulse", {31'd0, taken}, 32'd1);
    check("beq cnt", {16'd0, taken_cnt}, 32'd1);
    valid_br = 1'b0;
    step(); chk_pc("beq_fl1", 16'h001E, 1'b1);
    check("pulse ends", {31'd0, taken}, 32'd0);
    step(); chk_pc("beq_fl_done", 16'h0020, 1'b0);

    // Negative offset, always-taken
    valid_br = 1'b1; cond = 3'b111; offset = 9'h1FE;
    step(); chk_pc("b_neg", 16'h001E, 1'b1);
    check("b_neg cnt", {16'd0, taken_cnt}, 32'd2);
    valid_br = 1'b0;
    step(); chk_pc("b_neg_fl1", 16'h0020, 1'b1);
    step(); chk_pc("b_neg_fl2", 16'h0022, 1'b0);

    // Set V (Z stays 1), N=0: evaluate several conditions
    flags_in = 3'b010; flag_we = 3'b010;
    valid_br = 1'b1; cond = 3'b011; offset = 9'h004;
    step(); chk_pc("bn_not", 16'h0024, 1'b0);
    flag_we = 3'b000;
    cond = 3'b010;
    step(); chk_pc("bgt_not", 16'h0026, 1'b0);
    cond = 3'b000;
    step(); chk_pc("bne_not", 16'h0028, 1'b0);
    cond = 3'b101;
    step(); chk_pc("ble_taken", 16'h0032, 1'b1);
    check("ble cnt", {16'd0, taken_cnt}, 32'd3);
    valid_br = 1'b0;
    step(); chk_pc("ble_fl1", 16'h0034, 1'b1);
    step(); chk_pc("ble_fl2", 16'h0036, 1'b0);

    // Register-target form on V
    valid_br = 1'b1; br_reg = 1'b1; cond = 3'b110; br_addr = 16'hABCD;
    step(); chk_pc("br_v", 16'hABCD, 1'b1);
    check("br_v cnt", {16'd0, taken_cnt}, 32'd4);
    // Branch and halt during FLUSH are squashed
    cond = 3'b111; br_addr = 16'h1234; halt = 1'b1;
    step(); chk_pc("squash", 16'hABCF, 1'b1);
    check("squash halted", {31'd0, halted}, 32'd0);
    check("squash cnt", {16'd0, taken_cnt}, 32'd4);
    valid_br = 1'b0; halt = 1'b0; br_reg = 1'b0;
    step(); chk_pc("squash_done", 16'hABD1, 1'b0);

    // Stall during FLUSH
    valid_br = 1'b1; cond = 3'b111; offset = 9'h000;
    step(); chk_pc("stall_br", 16'hABD3, 1'b1);
    valid_br = 1'b0; stall = 1'b1;
    step(); chk_pc("stall1", 16'hABD3, 1'b1);
    step(); chk_pc("stall2", 16'hABD3, 1'b1);
    step(); chk_pc("stall3", 16'hABD3, 1'b1);
    stall = 1'b0;
    step(); chk_pc("stall_fl1", 16'hABD5, 1'b1);
    step(); chk_pc("stall_fl2", 16'hABD7, 1'b0);
    check("stall cnt", {16'd0, taken_cnt}, 32'd5);

    // Halt beats a simultaneous taken branch
    halt = 1'b1; valid_br = 1'b1; cond = 3'b111; offset = 9'h000;
    step(); chk_pc("halt", 16'hABD7, 1'b0);
    check("halt halted", {31'd0, halted}, 32'd1);
    check("halt taken", {31'd0, taken}, 32'd0);
    check("halt cnt", {16'd0, taken_cnt}, 32'd5);
    halt = 1'b0;
    step(); step(); chk_pc("halt_hold", 16'hABD7, 1'b0);
    check("halt sticky", {31'd0, halted}, 32'd1);

    // Asynchronous reset out of HALT
    valid_br = 1'b0;
    rst_n = 1'b0; #1;
    chk_pc("halt_rst", 16'h0000, 1'b0);
    check("halt_rst halted", {31'd0, halted}, 32'd0);
    check("halt_rst cnt", {16'd0, taken_cnt}, 32'd0);
    rst_n = 1'b1;
    step(); chk_pc("after_rst", 16'h0002, 1'b0);

    // Saturation: preload the count one below the ceiling
    force dut.r_taken_cnt = 16'hFFFE;
    #1;
    release dut.r_taken_cnt;
    valid_br = 1'b1; br_reg = 1'b1; cond = 3'b111; br_addr = 16'hFFFA;
    step(); chk_pc("sat1", 16'hFFFA, 1'b1);
    check("sat1 cnt", {16'd0, taken_cnt}, 32'h0000FFFF);
    valid_br = 1'b0; br_reg = 1'b0;
    step(); chk_pc("sat_fl1", 16'hFFFC, 1'b1);
    step(); chk_pc("sat_fl2", 16'hFFFE, 1'b0);
    // PC wrap
    step(); chk_pc("wrap", 16'h0000, 1'b0);
    valid_br = 1'b1; cond = 3'b111; offset = 9'h000;
    step(); chk_pc("sat2", 16'h0002, 1'b1);
    check("sat2 cnt", {16'd0, taken_cnt}, 32'h0000FFFF);
    check("sat2 taken", {31'd0, taken}, 32'd1);
    valid_br = 1'b0;

    // Reset asserted mid-FLUSH
    rst_n = 1'b0; #1;
    chk_pc("flush_rst", 16'h0000, 1'b0);
    check("flush_rst taken", {31'd0, taken}, 32'd0);
    check("flush_rst cnt", {16'd0, taken_cnt}, 32'd0);
    rst_n = 1'b1;
    step(); chk_pc("flush_rst_run", 16'h0002, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
